// File: rtl/spi_slv16_pkg.sv
// Shared types and constants for the 16-bit SPI responder (spi_slv16).
// The optional SPI_SLV_MISO_TRISTATE_EN build is handled in the top module.
package spi16_pkg;

    // Frame sequencing: waiting for select, shifting bits, frame complete.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } slv_state_t;

    localparam int FRAME_BITS  = 16;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slv16_if.sv
// Pin and command-side bundle for spi_slv16.
// Handshake: rdy is a single-clk strobe with no back-pressure. rd_data is
// valid in the rdy cycle and held until the next rdy. frm_err is a single-clk
// strobe that marks an incomplete frame.
interface spi_slv16_if;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [15:0] tx_data;
    logic [15:0] rd_data;
    logic        rdy;
    logic        busy;
    logic        frm_err;

    modport slave (
        input  SS_n, SCLK, MOSI, tx_data,
        output MISO, rd_data, rdy, busy, frm_err
    );

    modport master (
        output SS_n, SCLK, MOSI, tx_data,
        input  MISO, rd_data, rdy, busy, frm_err
    );
endinterface

// File: rtl/spi_slv16_sync_edge.sv
// Two-flop synchronizer with a delayed copy and rise/fall pulses.
// Edge pulses stay masked until the pipeline holds only real samples, so
// the reset value never looks like an edge when the pin sits at the other level.
module spi_sync_edge
    import spi16_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic dly,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic [SYNC_STAGES:0]   prime_q;

    // Synchronizer chain, edge-detect flop and pipeline-primed tracker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RST_VAL}};
            dly_q   <= RST_VAL;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
            dly_q   <= sync_q[SYNC_STAGES-1];
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign dly  = dly_q;
    assign rise = prime_q[SYNC_STAGES] &  lvl & ~dly_q;
    assign fall = prime_q[SYNC_STAGES] & ~lvl &  dly_q;

endmodule

// File: rtl/spi_slv16.sv
// 16-bit SPI responder, CPOL=1 CPHA=1, MSB first, oversampled on clk.
// Returns tx_data (captured at frame start) on MISO and delivers the
// received word on rd_data with a one-clk rdy strobe.
// Optional build macro: SPI_SLV_MISO_TRISTATE_EN (MISO high-Z while IDLE).
module spi_slv16
    import spi16_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    spi_slv16_if.slave   spi,
    output slv_state_t   state_dbg
);

    logic ss_lvl, ss_rise, ss_fall, ss_dly_unused;
    logic sclk_rise, sclk_fall, sclk_lvl_unused, sclk_dly_unused;
    logic mosi_lvl, mosi_dly_unused, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d(spi.SS_n),
        .lvl(ss_lvl), .dly(ss_dly_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst(rst), .d(spi.SCLK),
        .lvl(sclk_lvl_unused), .dly(sclk_dly_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(spi.MOSI),
        .lvl(mosi_lvl), .dly(mosi_dly_unused), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    slv_state_t  state_q, state_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] rd_q, rd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        rdy_q, rdy_d;
    logic        err_q, err_d;
    logic        busy_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers: shifters, bit count, received word and strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q  <= '0;
            rx_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
            err_q <= err_d;
        end
    end

    // busy mirrors the synchronized select level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= 1'b0;
        else     busy_q <= ~ss_lvl;
    end

    // Next-state and datapath updates; a select rise outranks any SCLK edge
    // in the same cycle so a partial frame is always reported.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    tx_d    = spi.tx_data;
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d = {rx_q[14:0], mosi_lvl};
                    if (cnt_q < 5'(FRAME_BITS)) cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(FRAME_BITS - 1)) begin
                        rd_d    = {rx_q[14:0], mosi_lvl};
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end
                end else if (sclk_fall && cnt_q != 5'd0) begin
                    // The first fall (count 0) is the front porch: MISO
                    // already shows bit 15, so nothing shifts.
                    tx_d = {tx_q[14:0], 1'b0};
                end
            end
            DONE: begin
                if (ss_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SPI_SLV_MISO_TRISTATE_EN
    assign spi.MISO = (state_q == IDLE) ? 1'bz : tx_q[15];
`else
    assign spi.MISO = (state_q == IDLE) ? 1'b0 : tx_q[15];
`endif

    assign spi.rd_data = rd_q;
    assign spi.rdy     = rdy_q;
    assign spi.frm_err = err_q;
    assign spi.busy    = busy_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_spi_slv16.sv
// Directed bench for spi_slv16: drives SPI frames as the master would
// (32-clk SCLK period) and checks MISO words, rd_data, strobes and timing.
module tb_spi_slv16;
    import spi16_pkg::*;

    logic       clk;
    logic       rst;
    slv_state_t state_dbg;

    spi_slv16_if spi_if();

    spi_slv16 dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi_if.slave),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rdy pops the expected received word.
    always @(negedge clk) begin
        if (spi_if.rdy) begin
            rdy_cnt++;
            if (exp_q.size() == 0)
                check("rdy_expected", 16'(exp_q.size() != 0), 16'd1);
            else
                check("rd_data", spi_if.rd_data, exp_q.pop_front());
        end
        if (spi_if.frm_err) err_cnt++;
    end

    // Master driver: nrise data rising edges; end_frame raises SS_n after.
    task automatic spi_frame(input logic [15:0] tx_w, input logic [15:0] tx_late,
                             input logic [15:0] mosi_w, input int nrise, input bit end_frame);
        logic [15:0] miso_w;
        int rdy0, err0;
        miso_w = '0;
        rdy0 = rdy_cnt;
        err0 = err_cnt;
        if (nrise == 16) exp_q.push_back(mosi_w);
        spi_if.tx_data = tx_w;
        spi_if.SS_n = 1'b0;
        wait_clk(2);
        check("busy_early", {15'b0, spi_if.busy}, 16'd0);
        wait_clk(1);
        check("busy_set", {15'b0, spi_if.busy}, 16'd1);
        wait_clk(5);
        spi_if.tx_data = tx_late;
        spi_if.SCLK = 1'b0;                 // front porch
        wait_clk(16);
        for (int i = 0; i < nrise; i++) begin
            spi_if.MOSI = mosi_w[15-i];
            miso_w[15-i] = spi_if.MISO;
            spi_if.SCLK = 1'b1;
            if (nrise == 16 && i == 15) begin
                wait_clk(2);
                check("rdy_early", {15'b0, spi_if.rdy}, 16'd0);
                wait_clk(1);
                check("rdy_3clk", {15'b0, spi_if.rdy}, 16'd1);
                wait_clk(13);
            end else begin
                wait_clk(16);
            end
            if (i < nrise - 1) begin
                spi_if.SCLK = 1'b0;
                wait_clk(16);
            end
        end
        if (end_frame) begin
            spi_if.SS_n = 1'b1;
            wait_clk(10);
            if (nrise == 16) begin
                check("miso_word", miso_w, tx_w);
                check("rdy_count", 16'(rdy_cnt - rdy0), 16'd1);
                check("err_none", 16'(err_cnt - err0), 16'd0);
            end else begin
                check("err_count", 16'(err_cnt - err0), 16'd1);
                check("rdy_none", 16'(rdy_cnt - rdy0), 16'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        spi_if.SS_n = 1'b1;
        spi_if.SCLK = 1'b1;
        spi_if.MOSI = 1'b0;
        spi_if.tx_data = '0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(5);

        // Reset state
        check("rst_rd_data", spi_if.rd_data, 16'h0000);
        check("rst_rdy", {15'b0, spi_if.rdy}, 16'd0);
        check("rst_busy", {15'b0, spi_if.busy}, 16'd0);
        check("rst_frm_err", {15'b0, spi_if.frm_err}, 16'd0);
        check("rst_state", {14'b0, state_dbg}, {14'b0, IDLE});
`ifdef SPI_SLV_MISO_TRISTATE_EN
        check("miso_idle", {15'b0, spi_if.MISO}, {15'b0, 1'bz});
`else
        check("miso_idle", {15'b0, spi_if.MISO}, 16'd0);
`endif

        // Full frame
        spi_frame(16'hA5C3, 16'hA5C3, 16'h1234, 16, 1'b1);
        check("rd_hold_1234", spi_if.rd_data, 16'h1234);

        // Back-to-back frames
        spi_frame(16'h0F0F, 16'h0F0F, 16'hFFFF, 16, 1'b1);
        spi_frame(16'hF0F0, 16'hF0F0, 16'h0001, 16, 1'b1);

        // Aborted frame keeps the previous word, then a clean frame
        spi_frame(16'h1111, 16'h1111, 16'hA0A0, 9, 1'b1);
        check("rd_kept", spi_if.rd_data, 16'h0001);
        spi_frame(16'h3C3C, 16'h3C3C, 16'hBEEF, 16, 1'b1);

        // Reset in the middle of a frame
        begin
            int rdy0, err0;
            rdy0 = rdy_cnt;
            err0 = err_cnt;
            spi_frame(16'hFFFF, 16'hFFFF, 16'h5A5A, 5, 1'b0);
            rst = 1'b1;
            #1;
            check("mid_rst_miso", {15'b0, spi_if.MISO}, 16'd0);
            check("mid_rst_rd_data", spi_if.rd_data, 16'h0000);
            check("mid_rst_busy", {15'b0, spi_if.busy}, 16'd0);
            check("mid_rst_rdy", {15'b0, spi_if.rdy}, 16'd0);
            check("mid_rst_frm_err", {15'b0, spi_if.frm_err}, 16'd0);
            spi_if.SS_n = 1'b1;
            spi_if.SCLK = 1'b1;
            wait_clk(3);
            rst = 1'b0;
            wait_clk(10);
            check("mid_rst_no_err", 16'(err_cnt - err0), 16'd0);
            check("mid_rst_no_rdy", 16'(rdy_cnt - rdy0), 16'd0);
        end
        spi_frame(16'h0000, 16'h0000, 16'h8001, 16, 1'b1);
        check("rd_8001", spi_if.rd_data, 16'h8001);

        // tx_data change after frame start is not seen by the master
        spi_frame(16'h5555, 16'h0000, 16'h6789, 16, 1'b1);

        check("sb_drain", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slv16.md
# spi_slv16

16-bit SPI responder: the slave end of the team's 16-bit SPI link, on the same SCLK/SS_n/MOSI/MISO wires the master drives. It runs entirely on the system clock and oversamples the SPI pins. Each frame, it returns a preloaded 16-bit word on MISO and captures the master's 16-bit command from MOSI. It sits behind the board SPI pins and hands received words to command-decode logic with a one-cycle ready strobe.

## Interface
- No parameters; frame length fixed at 16 bits.
- clk  input  1  system clock; sole clock domain.
- rst  input  1  reset, asynchronous, active-high.
- SS_n  input  1  slave select from master, active-low, asynchronous to clk.
- SCLK  input  1  SPI clock from master, idles high, asynchronous to clk.
- MOSI  input  1  master-out data, asynchronous to clk.
- MISO  output  1  slave-out data.
- tx_data  input  16  word returned to master; captured at frame start.
- rd_data  output  16  last complete received word; held until next complete frame.
- rdy  output  1  one-clk pulse when rd_data updates.
- busy  output  1  high while a frame is in progress (SS_n low, synchronized).
- frm_err  output  1  one-clk pulse when SS_n deasserts with bit count not 16.

## Operation
- Protocol mode:
  - CPOL=1, CPHA=1; MSB first.
  - Master samples MISO at SCLK rising and changes MOSI after SCLK falling.
  - The first SCLK fall after SS_n falls is a front-porch edge and carries no data.
- Input synchronization: SS_n, SCLK and MOSI each pass through two flops. A third flop on SS_n and SCLK provides edge detection.
- State machine, 2-bit enum:
  - IDLE:
    - On SS_n falling, load tx_shft <= tx_data, clear bit count, go to ACTIVE.
  - ACTIVE:
    - On SCLK rise, rx_shft <= {rx_shft[14:0], MOSI_sync} and count++.
    - On SCLK rise when count == 15 (16th bit), rd_data <= {rx_shft[14:0], MOSI_sync}, pulse rdy, go to DONE.
    - On SCLK fall with count != 0, tx_shft <= {tx_shft[14:0], 1'b0}.
    - On SCLK fall with count == 0 (front porch), do nothing.
    - On SS_n rising, pulse frm_err and go to IDLE.
  - DONE:
    - Ignore SCLK edges.
    - On SS_n rising, go to IDLE with no error.
- MISO = tx_shft[15] in ACTIVE and DONE. Bit 15 of tx_data appears at the first data rising edge.
- count is 5 bits and saturates at 16; it never wraps.
- Reset values:
  - MISO 0, rd_data 16'h0000, rdy 0, busy 0, frm_err 0.
  - State IDLE; shift registers and count 0.
- Reset mid-frame: return to IDLE immediately. The frame is lost and no rdy or frm_err is produced. The next SS_n fall starts a fresh frame.
- Simultaneous SCLK edge and SS_n rising in the same clk: SS_n wins. The edge is discarded; a partial frame gives frm_err.
- SS_n falling while not IDLE (glitch) is ignored until IDLE is reached.
- tx_data changes after frame start do not affect the current frame.

## Timing
- Pin-to-internal latency: 3 clk (2 sync flops plus 1 edge-detect flop).
- rdy rises 3 clk after the 16th SCLK rising edge at the pin. rd_data is valid in the same cycle and stable until the next rdy.
- MISO update: 3 clk after SCLK falls at the pin.
- SCLK constraints:
  - SCLK high and low phases must each be ≥ 6 clk.
  - The master's 32-clk SCLK period (16 clk per phase) satisfies this with 10 clk margin before its sampling point.
- SS_n falling to first SCLK falling: ≥ 4 clk, so tx_data is loaded before any edge.
- busy rises 3 clk after SS_n falls and falls 3 clk after SS_n rises.

## Configuration
- SPI_SLV_MISO_TRISTATE_EN:
  - Defined: MISO is high-impedance whenever state is IDLE, so multiple slaves can share the line.
  - Undefined: MISO is driven 0 in IDLE.
  - Reset value follows the same rule (Z when defined, 0 when undefined).

## Structure
- Package spi16_pkg holds:
  - the state enum slv_state_t {IDLE, ACTIVE, DONE};
  - localparam FRAME_BITS = 16;
  - localparam SYNC_STAGES = 2.
- Sub-module spi_sync_edge: one instance per input. It provides the 2-flop synchronizer, the delayed copy, and rise/fall pulse outputs. The MOSI instance uses only the synchronized level.

## Test plan
- Full frame: tx_data=16'hA5C3; master sends 16'h1234 at 32-clk SCLK period -> MISO bits read by master = 16'hA5C3; rd_data=16'h1234; exactly one rdy pulse; frm_err never set.
- Back-to-back frames: 16'hFFFF then 16'h0001 with tx_data 16'h0F0F then 16'hF0F0 -> two rdy pulses; rd_data 16'hFFFF then 16'h0001; master receives 16'h0F0F then 16'hF0F0.
- Aborted frame: SS_n rises after 9 SCLK rises -> one frm_err pulse, no rdy, rd_data keeps previous value; the following full frame 16'hBEEF is received correctly.
- Reset mid-frame: rst pulsed after 5 bits -> all outputs at reset values; the next frame 16'h8001 gives rd_data=16'h8001.
- tx_data changed to 16'h0000 mid-frame after loading 16'h5555 -> master still reads 16'h5555.
- Tristate build: with SPI_SLV_MISO_TRISTATE_EN defined, MISO=Z while SS_n high and driven during the frame; without it, MISO=0 while SS_n high.
